disp_scan_4digit: RTL and testbench

DISP_SCAN_4DIGIT -- requirements
Module: disp_scan_4digit

---
 rtl/disp_scan_4digit.sv | 101 ++++++++++
 tb/tb_disp_scan_4digit.sv | 110 +++++++++++
 2 files changed

// File: rtl/disp_scan_4digit.sv
// disp_scan_4digit: 4-digit multiplexed 7-segment scanner with per-frame input snapshot,
// leading-zero / forced blanking and decimal points; outputs active-low and registered.
module disp_scan_4digit #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] num,
  input  logic [3:0]  point,
  input  logic [3:0]  le,
  input  logic        zero_blank,
  output logic [3:0]  AN,
  output logic [7:0]  SEGMENT,
  output logic        frame_done
);
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic [15:0] num_sh_q, num_sh_d;
  logic [3:0]  point_sh_q, point_sh_d;
  logic [3:0]  le_sh_q, le_sh_d;
  logic        zb_sh_q, zb_sh_d;
  logic [3:0]  an_q, an_d;
  logic [7:0]  seg_q, seg_d;
  logic        fd_q, fd_d;
  logic        tick, wrap, blank;
  logic [15:0] upper;
  logic [3:0]  nib;
  logic [6:0]  hex;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    tick       = cnt_q == 16'(SCAN_DIV - 1);
    wrap       = tick && idx_q == 2'd3;
    cnt_d      = tick ? 16'd0 : cnt_q + 16'd1;
    idx_d      = tick ? idx_q + 2'd1 : idx_q;
    num_sh_d   = wrap ? num : num_sh_q;
    point_sh_d = wrap ? point : point_sh_q;
    le_sh_d    = wrap ? le : le_sh_q;
    zb_sh_d    = wrap ? zero_blank : zb_sh_q;
    valid_d    = valid_q | wrap;
    fd_d       = wrap;
    // a digit is a leading zero when it and every higher nibble are zero
    upper      = num_sh_q >> {idx_q, 2'b00};
    nib        = upper[3:0];
    hex        = seg7(nib);
    blank      = !valid_q || le_sh_q[idx_q] || (zb_sh_q && idx_q != 2'd0 && upper == 16'd0);
    an_d       = blank ? 4'hF : ~(4'b0001 << idx_q);
    seg_d      = blank ? 8'hFF : {~point_sh_q[idx_q], hex};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= 2'd3;
      valid_q    <= 1'b0;
      num_sh_q   <= '0;
      point_sh_q <= '0;
      le_sh_q    <= '0;
      zb_sh_q    <= 1'b0;
      an_q       <= 4'hF;
      seg_q      <= 8'hFF;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      num_sh_q   <= num_sh_d;
      point_sh_q <= point_sh_d;
      le_sh_q    <= le_sh_d;
      zb_sh_q    <= zb_sh_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      fd_q       <= fd_d;
    end
  end

  assign AN         = an_q;
  assign SEGMENT    = seg_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_disp_scan_4digit.sv
// tb_disp_scan_4digit: directed scan, snapshot, blanking, dp, decoder and async-reset checks
// against a queue of expected {AN, SEGMENT, frame_done} per clock.
module tb_disp_scan_4digit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] num = 16'hABCD;
  logic [3:0]  point = 4'h0;
  logic [3:0]  le = 4'h0;
  logic        zero_blank = 1'b0;
  logic [3:0]  AN;
  logic [7:0]  SEGMENT;
  logic        frame_done;
  int n_total = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic [12:0] sb[$];
  localparam logic [7:0] SEG_TAB [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  disp_scan_4digit #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .num(num), .point(point), .le(le), .zero_blank(zero_blank),
    .AN(AN), .SEGMENT(SEGMENT), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [12:0] exp);
    logic [12:0] obs;
    obs = {AN, SEGMENT, frame_done};
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: AN/SEG/fd got %b/%h/%b expected %b/%h/%b", tag,
             obs[12:9], obs[8:1], obs[0], exp[12:9], exp[8:1], exp[0]);
    end
  endtask

  // one digit slot lasts 4 clocks; frame_done is expected on the last clock of digit 3
  task automatic show(input string tag, input logic [3:0] an, input logic [7:0] seg, input bit last);
    for (int i = 0; i < 4; i++) sb.push_back({an, seg, last && i == 3});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk(tag, sb.pop_front());
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset", {4'hF, 8'hFF, 1'b0});
    rst_n = 1'b1;
    show("preblank", 4'hF, 8'hFF, 1);
    show("abcd_d0", 4'hE, 8'hA1, 0);
    num = 16'h1234;
    show("abcd_d1", 4'hD, 8'hC6, 0);
    show("snap_d2", 4'hB, 8'h83, 0);
    show("snap_d3", 4'h7, 8'h88, 1);
    show("n1234_d0", 4'hE, 8'h99, 0);
    show("n1234_d1", 4'hD, 8'hB0, 0);
    show("n1234_d2", 4'hB, 8'hA4, 0);
    num = 16'h0050;
    zero_blank = 1'b1;
    show("n1234_d3", 4'h7, 8'hF9, 1);
    show("lz50_d0", 4'hE, 8'hC0, 0);
    show("lz50_d1", 4'hD, 8'h92, 0);
    show("lz50_d2", 4'hF, 8'hFF, 0);
    num = 16'h0000;
    show("lz50_d3", 4'hF, 8'hFF, 1);
    show("lz0_d0", 4'hE, 8'hC0, 0);
    show("lz0_d1", 4'hF, 8'hFF, 0);
    show("lz0_d2", 4'hF, 8'hFF, 0);
    le = 4'b0001;
    show("lz0_d3", 4'hF, 8'hFF, 1);
    show("le_d0", 4'hF, 8'hFF, 0);
    show("le_d1", 4'hF, 8'hFF, 0);
    show("le_d2", 4'hF, 8'hFF, 0);
    le = 4'h0;
    zero_blank = 1'b0;
    num = 16'h8888;
    point = 4'b0100;
    show("le_d3", 4'hF, 8'hFF, 1);
    show("dp_d0", 4'hE, 8'h80, 0);
    show("dp_d1", 4'hD, 8'h80, 0);
    show("dp_d2", 4'hB, 8'h00, 0);
    point = 4'h0;
    num = 16'h0000;
    show("dp_d3", 4'h7, 8'h80, 1);
    for (int v = 0; v < 16; v++) begin
      show("dec_d0", 4'hE, SEG_TAB[v], 0);
      show("dec_d1", 4'hD, 8'hC0, 0);
      show("dec_d2", 4'hB, 8'hC0, 0);
      num = (v == 15) ? 16'hABCD : 16'(v + 1);
      show("dec_d3", 4'h7, 8'hC0, 1);
    end
    show("pre_rst_d0", 4'hE, 8'hA1, 0);
    show("pre_rst_d1", 4'hD, 8'hC6, 0);
    @(negedge clk);
    chk("pre_rst_d2", {4'hB, 8'h83, 1'b0});
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {4'hF, 8'hFF, 1'b0});
    @(negedge clk);
    chk("rst_hold", {4'hF, 8'hFF, 1'b0});
    rst_n = 1'b1;
    show("rst_preblank", 4'hF, 8'hFF, 1);
    show("rst_d0", 4'hE, 8'hA1, 0);
    show("rst_d1", 4'hD, 8'hC6, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
